clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Programmable integer clock divider with a ratio-update handshake. It produces a registered divided clock `clk_out` and a one-cycle `tick` at each output period start. It sits ahead of the fixed divide-by-two stage in the clock-generation chain and supplies that stage's input clock. Ratio changes take effect only at period boundaries, so no runt pulses are produced.

## Interface
- `CNT_W`, default 8: width of the ratio and the counter.
- `DEF_DIV`, default 4: ratio after reset. Legal range is 2 .. 2^CNT_W-1.

- `clk_in` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: count enable. When low, all state is frozen.
- `div_val` in CNT_W: requested ratio N. Values 0 and 1 are treated as 2.
- `div_req` in 1: ratio-change request (level). Held high with `div_val` stable until `div_ack`.
- `div_ack` out 1: one-cycle pulse; the new ratio is now active.
- `clk_out` out 1: divided clock, registered.
- `tick` out 1: one-cycle pulse at the period start (first high cycle of `clk_out`).
- `cur_div` out CNT_W: active ratio, after clamping.

## Operation
- **State:**
  - `cnt` (CNT_W)
  - `n_act` (CNT_W, drives `cur_div`)
  - `clk_out`, `tick`, `div_ack` registers
- **Derived values:**
  - `H = n_act >> 1` is the high-phase length.
  - Low phase is `n_act - H`.
  - For odd N the low phase is one cycle longer than the high phase.
- **Reset (`rst`=1 at an edge):**
  - `cnt = DEF_DIV-1`
  - `n_act = DEF_DIV`
  - `clk_out = 0`, `tick = 0`, `div_ack = 0`
- **Normal edge (`en`=1, `rst`=0):**
  - If `cnt == n_act-1` (boundary): `cnt_nx = 0`; otherwise `cnt_nx = cnt+1`.
  - `cnt <= cnt_nx`
  - `clk_out <= (cnt_nx < H_nx)`
  - `tick <= (cnt_nx == 0)`
  - `H_nx` is derived from the ratio in force after this edge.
- **Ratio update:**
  - Accepted only on a boundary edge with `en`=1, `div_req`=1 and `div_ack`=0.
  - `div_ack`=0 blocks re-acceptance of a request not yet dropped.
  - On acceptance: `n_act <= max(div_val, 2)` and `div_ack <= 1`.
  - The new period starts at that same edge using the new ratio, so `tick`, `div_ack` and the new `clk_out` high phase coincide.
- **Request hold:** while `div_req`=1 away from a boundary, nothing happens and the request stays pending.
- **Enable low (`en`=0):**
  - `cnt`, `n_act` and `clk_out` hold.
  - `tick` and `div_ack` are forced to 0.
  - No request is accepted.
- **Boundary conditions:**
  - If `div_req` and `en` both go high on a boundary edge, the request is accepted.
  - Requesting a ratio equal to `n_act` still handshakes normally.
  - `rst` asserted mid-period overrides everything. A pending request is discarded; the requester must re-raise it.
  - `div_val` > 2^CNT_W-1 cannot occur by width.

## Timing
- Latency from a boundary edge to output is 0 cycles: outputs are registered, so the values computed at edge E appear after E.
- **First period:** the first `en`=1 edge after reset is a boundary. After it: `cnt`=0, `clk_out`=1, `tick`=1.
- **Period length:** exactly `n_act` `clk_in` cycles.
  - `clk_out` is high for H cycles, then low for `n_act-H` cycles.
  - `tick` is high in the first cycle of every period.
- **Request latency:** from `div_req` rising to `div_ack` is at most `n_act` cycles, plus any cycles with `en`=0.
- **Handshake rule:**
  - The requester drops `div_req` on the edge after it samples `div_ack`=1.
  - Because `div_ack` blocks acceptance, a one-cycle late drop never causes a double accept, even at N=2.
- **Output glitching:** `clk_out` changes only at `clk_in` rising edges. It is glitch-free by construction; no combinational path reaches the output.

## Test plan
- **Reset and default ratio:** hold `rst` for 3 cycles, then `rst`=0, `en`=1 with `DEF_DIV`=4.
  - Required: `clk_out` = 1,1,0,0 repeating.
  - `tick` high every 4th cycle, starting on the first edge.
  - `cur_div`=4.
- **Odd ratio:** request `div_val`=5.
  - `div_ack` arrives on a boundary edge, in the same cycle as `tick`.
  - Thereafter `clk_out` = 1,1,0,0,0 and period = 5.
  - `div_ack` stays high for exactly 1 cycle.
- **Clamp and N=2 stress:** request `div_val`=0, holding `div_req` one extra cycle past `div_ack`.
  - Required: `cur_div`=2 and `clk_out` toggles every cycle.
  - Exactly one `div_ack` pulse is produced.
- **Enable gating:** at N=6, drop `en` for 4 cycles mid high phase.
  - `clk_out` and `cnt` freeze and `tick` stays 0.
  - On resume the period completes with its remaining cycles; no phase is lost or repeated.
- **Reset mid-operation:** at N=7 with a pending `div_req`, assert `rst` at `cnt`=3.
  - Required: `clk_out`=0, `cur_div`=`DEF_DIV`, no `div_ack`.
  - The next `en`=1 edge starts a fresh period.
- **Back-to-back requests:** request 3, then 8 immediately after the first `div_ack`.
  - The second `div_ack` comes exactly 3 cycles after the first.
  - Period lengths observed: 3, then 8.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with a ratio-update handshake.
// Generates a registered divided clock and a one-cycle tick at each period start.
// A new ratio is only adopted at a period boundary, so clk_out never produces runt pulses.
module clk_div_prog #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_req,
  output logic             div_ack,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] cur_div
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MinDiv = CNT_W'(2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_act_q, n_act_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             div_ack_q, div_ack_d;

  logic             boundary;
  logic             accept;
  logic [CNT_W-1:0] div_clamped;
  logic [CNT_W-1:0] half_nx;

  // Next-state: advance the period counter and adopt a pending ratio at a boundary.
  always_comb begin
    boundary    = (cnt_q == (n_act_q - CNT_W'(1)));
    // div_ack_q blocks a second accept while the requester is still dropping div_req.
    accept      = en & boundary & div_req & ~div_ack_q;
    div_clamped = (div_val < MinDiv) ? MinDiv : div_val;

    cnt_d     = cnt_q;
    n_act_d   = n_act_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    div_ack_d = 1'b0;
    half_nx   = n_act_q >> 1;

    if (en) begin
      if (accept) begin
        n_act_d = div_clamped;
      end
      cnt_d     = boundary ? '0 : cnt_q + CNT_W'(1);
      // High phase uses the ratio in force after this edge, so a new ratio starts cleanly.
      half_nx   = n_act_d >> 1;
      clk_out_d = (cnt_d < half_nx);
      tick_d    = (cnt_d == '0);
      div_ack_d = accept;
    end
  end

  // State registers with synchronous active-high reset; reset parks cnt on a boundary.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q     <= DefDiv - CNT_W'(1);
      n_act_q   <= DefDiv;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      div_ack_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      n_act_q   <= n_act_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      div_ack_q <= div_ack_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign div_ack = div_ack_q;
  assign cur_div = n_act_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: directed per-cycle vectors push expected outputs,
// a monitor pops and compares after every rising edge.
module tb_clk_div_prog;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] div_val = 8'd0;
  logic       div_req = 1'b0;
  logic       div_ack;
  logic       clk_out;
  logic       tick;
  logic [7:0] cur_div;

  typedef struct packed {
    logic       co;
    logic       tk;
    logic       ak;
    logic [7:0] dv;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  clk_div_prog #(
    .CNT_W  (8),
    .DEF_DIV(4)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (en),
    .div_val(div_val),
    .div_req(div_req),
    .div_ack(div_ack),
    .clk_out(clk_out),
    .tick   (tick),
    .cur_div(cur_div)
  );

  always #5 clk_in = ~clk_in;

  // Apply n cycles of constant inputs; patterns read left to right in time (MSB first).
  task automatic run(input int n, input logic r, input logic e, input logic rq,
                     input logic [7:0] v, input logic [31:0] cp, input logic [31:0] tp,
                     input logic [31:0] ap, input logic [7:0] dv, input string name);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      rst     = r;
      en      = e;
      div_req = rq;
      div_val = v;
      x.co = cp[n-1-i];
      x.tk = tp[n-1-i];
      x.ak = ap[n-1-i];
      x.dv = dv;
      exp_q.push_back(x);
      name_q.push_back(name);
    end
  endtask

  // Monitor: compare DUT outputs just after each rising edge against the scoreboard.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {clk_out, tick, div_ack, cur_div};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s @%0t: got clk_out=%b tick=%b div_ack=%b cur_div=%0d, want clk_out=%b tick=%b div_ack=%b cur_div=%0d",
                   nm, $time, a.co, a.tk, a.ak, a.dv, e.co, e.tk, e.ak, e.dv);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset and default ratio 4: clk_out 1100, tick on first edge.
    run(3, 1, 0, 0, 8'd0, 32'd0, 32'd0, 32'd0, 8'd4, "reset");
    run(8, 0, 1, 0, 8'd0, 8'b11001100, 8'b10001000, 32'd0, 8'd4, "div4");
    run(2, 0, 1, 0, 8'd0, 2'b11, 2'b10, 32'd0, 8'd4, "div4_b");

    // Odd ratio 5: request pends mid-period, acks with tick at the boundary.
    run(2, 0, 1, 1, 8'd5, 2'b00, 2'b00, 32'd0, 8'd4, "req5_hold");
    run(1, 0, 1, 1, 8'd5, 32'd1, 32'd1, 32'd1, 8'd5, "ack5");
    run(9, 0, 1, 0, 8'd0, 9'b100011000, 9'b000010000, 32'd0, 8'd5, "div5");

    // Clamp 0 -> 2, request held one extra cycle past div_ack: single ack only.
    run(1, 0, 1, 1, 8'd0, 32'd1, 32'd1, 32'd1, 8'd2, "ack_clamp");
    run(1, 0, 1, 1, 8'd0, 32'd0, 32'd0, 32'd0, 8'd2, "req_late");
    run(6, 0, 1, 0, 8'd0, 6'b101010, 6'b101010, 32'd0, 8'd2, "div2");

    // Enable gating at N=6 during the high phase.
    run(1, 0, 1, 1, 8'd6, 32'd1, 32'd1, 32'd1, 8'd6, "ack6");
    run(1, 0, 1, 0, 8'd0, 32'd1, 32'd0, 32'd0, 8'd6, "div6_pre");
    run(4, 0, 0, 0, 8'd0, 4'b1111, 4'b0000, 32'd0, 8'd6, "freeze");
    run(6, 0, 1, 0, 8'd0, 6'b100011, 6'b000010, 32'd0, 8'd6, "resume");

    // Move to N=7, then reset at cnt=3 with a pending request.
    run(4, 0, 1, 1, 8'd7, 4'b1000, 4'b0000, 32'd0, 8'd6, "req7_hold");
    run(1, 0, 1, 1, 8'd7, 32'd1, 32'd1, 32'd1, 8'd7, "ack7");
    run(3, 0, 1, 0, 8'd0, 3'b110, 3'b000, 32'd0, 8'd7, "div7");
    run(2, 1, 1, 1, 8'd5, 32'd0, 32'd0, 32'd0, 8'd4, "rst_mid");
    run(4, 0, 1, 0, 8'd0, 4'b1100, 4'b1000, 32'd0, 8'd4, "fresh");

    // Back-to-back: 3 then 8; second ack exactly 3 cycles after the first.
    run(1, 0, 1, 1, 8'd3, 32'd1, 32'd1, 32'd1, 8'd3, "ack3");
    run(2, 0, 1, 1, 8'd8, 2'b00, 2'b00, 2'b00, 8'd3, "p3");
    run(1, 0, 1, 1, 8'd8, 32'd1, 32'd1, 32'd1, 8'd8, "ack8");
    run(8, 0, 1, 0, 8'd0, 8'b11100001, 8'b00000001, 32'd0, 8'd8, "p8");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk_in);
      #2;
    end
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
